mx_block_sequencer: RTL and testbench

- Accepts one MX block per handshake: shared 8-bit scale plus BLOCK_SIZE packed elements in any supported MX element format.
- Sequences the block into LANES-wide beats for the downstream element ALU.
- Unpacks each element into an 8-bit lane slot and tags each beat with scale, format, index and first/last markers.
- Sits between the MX operand buffer and the shared per-lane MX datapath.

---
 rtl/mx_block_sequencer.sv | 129 ++++++++++++
 tb/tb_mx_block_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_block_sequencer.sv
// MX block sequencer: captures one scaled MX block and issues it as LANES-wide beats
// of zero-extended 8-bit element slots tagged with scale, format and position.
module mx_block_sequencer #(
   parameter int BLOCK_SIZE = 32,
   parameter int LANES      = 4,
   parameter int SCALE_BITS = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_fmt,
   input  logic [SCALE_BITS-1:0]         in_scale,
   input  logic [8*BLOCK_SIZE-1:0]       in_elements,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2:0]                    out_fmt,
   output logic [SCALE_BITS-1:0]         out_scale,
   output logic [8*LANES-1:0]            out_lanes,
   output logic [$clog2(BLOCK_SIZE)-1:0] out_index,
   output logic                          out_first,
   output logic                          out_last,
   output logic                          busy,
   output logic                          fmt_err
);

   localparam int NBEATS = BLOCK_SIZE / LANES;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int IDX_W  = $clog2(BLOCK_SIZE);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [BEAT_W-1:0]       r_beat;
   logic [2:0]              r_fmt;
   logic [SCALE_BITS-1:0]   r_scale;
   logic [8*BLOCK_SIZE-1:0] r_slots;
   logic                    r_fmt_err;
   logic [8*BLOCK_SIZE-1:0] w_slots;
   logic                    w_legal;
   logic                    w_accept;
   logic                    w_last;
   logic                    w_beat_done;

   // Element idx of a block packed at the format's native width, zero-extended.
   function automatic logic [7:0] f_unpack(input logic [8*BLOCK_SIZE-1:0] elems,
                                           input logic [2:0] fmt, input int idx);
      logic [7:0] v;
      v = '0;
      case (fmt)
         3'd2, 3'd3: v = {2'b00, elems[idx*6 +: 6]};
         3'd4:       v = {4'h0, elems[idx*4 +: 4]};
         default:    v = elems[idx*8 +: 8];
      endcase
      return v;
   endfunction

   // Unpacking happens at capture so the beat mux only selects fixed 8-bit slots.
   always_comb begin
      w_slots = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         w_slots[i*8 +: 8] = f_unpack(in_elements, in_fmt, i);
      end
   end

   assign w_legal     = (in_fmt <= 3'd5);
   assign w_last      = (r_state == STREAM) && (r_beat == LAST_BEAT);
   assign w_beat_done = (r_state == STREAM) && out_ready;
   // Combinational from out_ready so a new block can follow the last beat with no bubble.
   assign in_ready    = rst_n && ((r_state == IDLE) || (out_ready && w_last));
   assign w_accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && w_legal) w_next = STREAM;
         end
         STREAM: begin
            if (w_beat_done && w_last) w_next = (w_accept && w_legal) ? STREAM : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (r_state == STREAM);
      busy      = (r_state == STREAM);
      out_first = (r_state == STREAM) && (r_beat == '0);
      out_last  = w_last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_beat    <= '0;
         r_fmt     <= '0;
         r_scale   <= '0;
         r_slots   <= '0;
         r_fmt_err <= 1'b0;
      end else begin
         r_fmt_err <= w_accept && !w_legal;
         if (w_accept && w_legal) begin
            r_beat  <= '0;
            r_fmt   <= in_fmt;
            r_scale <= in_scale;
            r_slots <= w_slots;
         end else if (w_beat_done) begin
            r_beat <= w_last ? '0 : r_beat + 1'b1;
         end
      end
   end

   assign out_lanes = r_slots[int'(r_beat)*8*LANES +: 8*LANES];
   assign out_index = IDX_W'(int'(r_beat) * LANES);
   assign out_fmt   = r_fmt;
   assign out_scale = r_scale;
   assign fmt_err   = r_fmt_err;

endmodule

// File: tb/tb_mx_block_sequencer.sv
// Bench for mx_block_sequencer: directed scenarios plus randomized traffic, all
// checked every cycle against a block/beat-level reference model.
module tb_mx_block_sequencer;

   localparam int BS = 32;
   localparam int L  = 4;
   localparam int SB = 8;
   localparam int NB = BS / L;

   logic             clk = 1'b0;
   logic             d_rst_n;
   logic             d_in_valid;
   logic             in_ready;
   logic [2:0]       d_fmt;
   logic [SB-1:0]    d_scale;
   logic [8*BS-1:0]  d_elems;
   logic             out_valid;
   logic             d_out_ready;
   logic [2:0]       out_fmt;
   logic [SB-1:0]    out_scale;
   logic [8*L-1:0]   out_lanes;
   logic [4:0]       out_index;
   logic             out_first;
   logic             out_last;
   logic             busy;
   logic             fmt_err;

   mx_block_sequencer #(.BLOCK_SIZE(BS), .LANES(L), .SCALE_BITS(SB)) dut (
      .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(in_ready),
      .in_fmt(d_fmt), .in_scale(d_scale), .in_elements(d_elems),
      .out_valid(out_valid), .out_ready(d_out_ready), .out_fmt(out_fmt),
      .out_scale(out_scale), .out_lanes(out_lanes), .out_index(out_index),
      .out_first(out_first), .out_last(out_last), .busy(busy), .fmt_err(fmt_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: the block currently being streamed and which beat is shown.
   bit          m_active;
   int          m_beat;
   bit          m_err;
   logic [7:0]  m_el [BS];
   logic [7:0]  m_scale;
   logic [2:0]  m_fmt;
   logic [7:0]  g_src [BS];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int fmt_w(input logic [2:0] f);
      case (f)
         3'd0, 3'd1, 3'd5: return 8;
         3'd2, 3'd3:       return 6;
         3'd4:             return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic logic [8*BS-1:0] pack_src(input logic [2:0] f, input bit fill);
      logic [8*BS-1:0] v;
      int w;
      v = fill ? '1 : '0;
      w = fmt_w(f);
      for (int i = 0; i < BS; i++)
         for (int b = 0; b < w; b++) v[i*w + b] = g_src[i][b];
      return v;
   endfunction

   // Inputs are set at the falling edge; one call covers one rising edge.
   task automatic step();
      bit   exp_rdy, acc, lastb;
      int   w;
      logic [31:0] exp_l;
      #1;
      lastb   = m_active && (m_beat == NB - 1);
      exp_rdy = d_rst_n && (!m_active || (d_out_ready && lastb));
      chk("in_ready", in_ready, exp_rdy);
      @(posedge clk);
      acc = d_in_valid && exp_rdy;
      if (!d_rst_n) begin
         m_active = 0; m_beat = 0; m_err = 0; m_scale = '0; m_fmt = '0;
         for (int i = 0; i < BS; i++) m_el[i] = '0;
      end else begin
         m_err = acc && (d_fmt > 3'd5);
         if (m_active && d_out_ready) begin
            if (lastb) begin m_active = 0; m_beat = 0; end
            else m_beat++;
         end
         if (acc && d_fmt <= 3'd5) begin
            m_active = 1; m_beat = 0; m_scale = d_scale; m_fmt = d_fmt;
            w = fmt_w(d_fmt);
            for (int i = 0; i < BS; i++) begin
               m_el[i] = '0;
               for (int b = 0; b < w; b++) m_el[i][b] = d_elems[i*w + b];
            end
         end
      end
      @(negedge clk);
      chk("out_valid", out_valid, m_active);
      chk("busy", busy, m_active);
      chk("fmt_err", fmt_err, m_err);
      if (m_active) begin
         for (int k = 0; k < L; k++) exp_l[k*8 +: 8] = m_el[m_beat*L + k];
         chk("out_lanes", out_lanes, exp_l);
         chk("out_index", out_index, m_beat * L);
         chk("out_first", out_first, m_beat == 0);
         chk("out_last", out_last, m_beat == NB - 1);
         chk("out_scale", out_scale, m_scale);
         chk("out_fmt", out_fmt, m_fmt);
      end else begin
         chk("idle_first", out_first, 0);
         chk("idle_last", out_last, 0);
      end
   endtask

   task automatic accept(input logic [2:0] f, input logic [7:0] s, input bit fill);
      d_fmt = f; d_scale = s; d_elems = pack_src(f, fill); d_in_valid = 1'b1;
      step();
      d_in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 64 && m_active; i++) step();
      chk(tag, busy, 0);
   endtask

   int cnt;
   int stall;

   initial begin
      d_rst_n = 1'b0; d_in_valid = 1'b0; d_fmt = '0; d_scale = '0; d_elems = '0;
      d_out_ready = 1'b1;
      m_active = 0; m_beat = 0; m_err = 0; m_scale = '0; m_fmt = '0;
      for (int i = 0; i < BS; i++) m_el[i] = '0;
      @(negedge clk);
      step(); step();
      chk("rst_lanes", out_lanes, 0);
      chk("rst_index", out_index, 0);
      chk("rst_scale", out_scale, 0);
      chk("rst_fmt", out_fmt, 0);
      d_rst_n = 1'b1;

      // E4M3 ramp
      for (int i = 0; i < BS; i++) g_src[i] = 8'(i);
      accept(3'd1, 8'h7F, 0);
      chk("t1_beat0", out_lanes, 32'h03020100);
      chk("t1_first", out_first, 1);
      chk("t1_idx0", out_index, 0);
      repeat (7) step();
      chk("t1_beat7", out_lanes, 32'h1F1E1D1C);
      chk("t1_last", out_last, 1);
      chk("t1_idx7", out_index, 28);
      chk("t1_scale", out_scale, 8'h7F);
      step();
      chk("t1_busy_drop", busy, 0);

      // E2M1 with the unused upper half driven to ones
      for (int i = 0; i < BS; i++) g_src[i] = 8'(i % 16);
      accept(3'd4, 8'h11, 1);
      step();
      chk("t2_beat1", out_lanes, 32'h07060504);
      repeat (3) step();
      chk("t2_beat4", out_lanes, 32'h03020100);
      drain("t2_drain");

      // E3M2 descending
      for (int i = 0; i < BS; i++) g_src[i] = 8'(8'h3F - i);
      accept(3'd2, 8'h05, 0);
      chk("t3_beat0", out_lanes, 32'h3C3D3E3F);
      drain("t3_drain");

      // Backpressure on beat 2
      for (int i = 0; i < BS; i++) g_src[i] = 8'($urandom);
      accept(3'd0, 8'h22, 0);
      cnt = 0; stall = 0;
      for (int i = 0; i < 40 && out_valid; i++) begin
         cnt++;
         d_out_ready = !(out_index == 5'd8 && stall < 3);
         if (!d_out_ready) stall++;
         step();
         if (!d_out_ready) chk("t4_hold_idx", out_index, 8);
      end
      d_out_ready = 1'b1;
      chk("t4_cycles", cnt, 11);

      // Back-to-back blocks
      for (int i = 0; i < BS; i++) g_src[i] = 8'($urandom);
      accept(3'd1, 8'h33, 0);
      for (int i = 0; i < 20 && !out_last; i++) step();
      for (int i = 0; i < BS; i++) g_src[i] = 8'($urandom);
      d_fmt = 3'd5; d_scale = 8'h80; d_elems = pack_src(3'd5, 0); d_in_valid = 1'b1;
      #1 chk("t5_ready", in_ready, 1);
      step();
      d_in_valid = 1'b0;
      chk("t5_valid", out_valid, 1);
      chk("t5_first", out_first, 1);
      chk("t5_scale", out_scale, 8'h80);
      drain("t5_drain");

      // Illegal format in IDLE
      accept(3'd6, 8'h44, 0);
      chk("t6_err", fmt_err, 1);
      chk("t6_valid", out_valid, 0);
      step();
      chk("t6_err_clear", fmt_err, 0);

      // Reset in the middle of a block
      for (int i = 0; i < BS; i++) g_src[i] = 8'($urandom);
      accept(3'd3, 8'h55, 0);
      repeat (3) step();
      d_rst_n = 1'b0;
      step();
      chk("t7_valid", out_valid, 0);
      chk("t7_busy", busy, 0);
      d_rst_n = 1'b1;
      #1 chk("t7_ready", in_ready, 1);
      step();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         d_rst_n     = ($urandom_range(0, 149) != 0);
         d_in_valid  = ($urandom_range(0, 2) == 0);
         d_fmt       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                   : 3'($urandom_range(0, 5));
         d_scale     = 8'($urandom);
         for (int w = 0; w < 8; w++) d_elems[w*32 +: 32] = $urandom;
         d_out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
